// File: rtl/show_sw_hist.sv
// Debounced active-low switch bank with a shift history of distinct values,
// shown on a scanned 7-segment display. Optional macro: SHOW_SW_CHG_CNT_EN.
module show_sw_hist #(
    parameter int SW_W       = 4,
    parameter int NUM_DIGITS = 8,
    parameter int HIST_DEPTH = 4,
    parameter int DEB_CYCLES = 20000,
    parameter int SCAN_DIV   = 10000
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [SW_W-1:0]       switch,
    output logic [NUM_DIGITS-1:0] num_csn,
    output logic [6:0]            num_a_g,
    output logic [SW_W-1:0]       led
);

    localparam int DEB_W  = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int HC_W   = $clog2(HIST_DEPTH + 1);

    logic [SW_W-1:0]   sync1_q, sync_q, cand_q, cur_q;
    logic [DEB_W-1:0]  deb_cnt_q;
    logic [SW_W-1:0]   hist_q [HIST_DEPTH];
    logic [HC_W-1:0]   hist_cnt_q, hist_cnt_d;
    logic [SCAN_W-1:0] scan_cnt_q;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              deb_done, scan_wrap;
    logic [3:0]        dig_val;
    logic              dig_on;
`ifdef SHOW_SW_CHG_CNT_EN
    logic [3:0]        chg_cnt_q;
`endif

    function automatic logic [6:0] seg7(input logic [3:0] v);
        case (v)
            4'h0: seg7 = 7'h7E;
            4'h1: seg7 = 7'h30;
            4'h2: seg7 = 7'h6D;
            4'h3: seg7 = 7'h79;
            4'h4: seg7 = 7'h33;
            4'h5: seg7 = 7'h5B;
            4'h6: seg7 = 7'h5F;
            4'h7: seg7 = 7'h70;
            4'h8: seg7 = 7'h7F;
            4'h9: seg7 = 7'h7B;
            4'hA: seg7 = 7'h77;
            4'hB: seg7 = 7'h1F;
            4'hC: seg7 = 7'h4E;
            4'hD: seg7 = 7'h3D;
            4'hE: seg7 = 7'h4F;
            default: seg7 = 7'h47;
        endcase
    endfunction

    // A candidate is accepted only after DEB_CYCLES consecutive stable samples.
    assign deb_done = (sync_q == cand_q) && (cand_q != cur_q)
                    && (deb_cnt_q == DEB_W'(DEB_CYCLES - 1));
    assign hist_cnt_d = (hist_cnt_q == HC_W'(HIST_DEPTH)) ? hist_cnt_q
                                                          : hist_cnt_q + 1'b1;
    assign scan_wrap = (scan_cnt_q == SCAN_W'(SCAN_DIV - 1));
    assign idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;

    always_comb begin
        dig_val = '0;
        dig_on  = 1'b0;
        if (idx_q == '0) begin
            dig_val = 4'(cur_q);
            dig_on  = 1'b1;
        end
        for (int k = 1; k <= HIST_DEPTH; k++) begin
            if (idx_q == IDX_W'(k) && k <= int'(hist_cnt_q)) begin
                dig_val = 4'(hist_q[k-1]);
                dig_on  = 1'b1;
            end
        end
`ifdef SHOW_SW_CHG_CNT_EN
        if (idx_q == IDX_W'(NUM_DIGITS - 1)) begin
            dig_val = chg_cnt_q;
            dig_on  = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync1_q    <= '0;
            sync_q     <= '0;
            cand_q     <= '0;
            cur_q      <= '0;
            deb_cnt_q  <= '0;
            hist_cnt_q <= '0;
            for (int i = 0; i < HIST_DEPTH; i++) hist_q[i] <= '0;
            scan_cnt_q <= '0;
            idx_q      <= '0;
            num_csn    <= '1;
            num_a_g    <= '0;
            led        <= '1;
`ifdef SHOW_SW_CHG_CNT_EN
            chg_cnt_q  <= '0;
`endif
        end else begin
            sync1_q <= ~switch;
            sync_q  <= sync1_q;
            if (sync_q != cand_q) begin
                cand_q    <= sync_q;
                deb_cnt_q <= '0;
            end else if (cand_q != cur_q) begin
                deb_cnt_q <= deb_done ? '0 : deb_cnt_q + 1'b1;
            end else begin
                deb_cnt_q <= '0;
            end
            if (deb_done) begin
                cur_q      <= cand_q;
                hist_q[0]  <= cur_q;
                for (int i = 1; i < HIST_DEPTH; i++) hist_q[i] <= hist_q[i-1];
                hist_cnt_q <= hist_cnt_d;
`ifdef SHOW_SW_CHG_CNT_EN
                chg_cnt_q  <= chg_cnt_q + 1'b1;
`endif
            end
            led <= ~hist_q[0];
            scan_cnt_q <= scan_wrap ? '0 : scan_cnt_q + 1'b1;
            if (scan_wrap) idx_q <= idx_d;
            // Select and segments come from the same idx so they never disagree.
            num_csn <= ~(NUM_DIGITS'(1) << idx_q);
            num_a_g <= dig_on ? seg7(dig_val) : 7'h00;
        end
    end

endmodule

// File: tb/tb_show_sw_hist.sv
// Directed self-checking bench for show_sw_hist (small debounce/scan settings).
module tb_show_sw_hist;

    logic       clk = 1'b0;
    logic       resetn;
    logic [3:0] switch;
    logic [7:0] num_csn;
    logic [6:0] num_a_g;
    logic [3:0] led;

    int tests_run = 0;
    int tests_failed = 0;

    show_sw_hist #(
        .SW_W(4), .NUM_DIGITS(8), .HIST_DEPTH(4), .DEB_CYCLES(4), .SCAN_DIV(2)
    ) dut (
        .clk(clk), .resetn(resetn), .switch(switch),
        .num_csn(num_csn), .num_a_g(num_a_g), .led(led)
    );

    always #5 clk = ~clk;

    // Waits (bounded) until digit d is selected, then returns its segments.
    task automatic wait_digit(input int d, output bit ok, output logic [6:0] seg);
        logic [7:0] sel;
        sel = 8'b1 << d;
        ok  = 1'b0;
        seg = '0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (num_csn == ~sel) begin
                ok  = 1'b1;
                seg = num_a_g;
                break;
            end
        end
    endtask

    task automatic test_reset();
        bit ok;
        resetn = 1'b0;
        switch = 4'hF;
        repeat (50) @(negedge clk);
        tests_run++;
        if (num_csn !== 8'hFF) begin tests_failed++; $display("FAIL reset_csn got %h want FF", num_csn); end
        tests_run++;
        if (num_a_g !== 7'h00) begin tests_failed++; $display("FAIL reset_seg got %h want 00", num_a_g); end
        tests_run++;
        if (led !== 4'hF) begin tests_failed++; $display("FAIL reset_led got %h want F", led); end
        resetn = 1'b1;
        @(negedge clk);
        tests_run++;
        if (num_csn !== 8'hFE) begin tests_failed++; $display("FAIL first_csn got %h want FE", num_csn); end
        tests_run++;
        if (num_a_g !== 7'h7E) begin tests_failed++; $display("FAIL first_seg got %h want 7E", num_a_g); end
    endtask

    task automatic test_debounce();
        bit ok;
        logic [6:0] s;
        switch = 4'h8;
        repeat (6) @(negedge clk);
        tests_run++;
        if (dut.cur_q !== 4'h0) begin tests_failed++; $display("FAIL latency_early cur got %h want 0", dut.cur_q); end
        @(negedge clk);
        tests_run++;
        if (dut.cur_q !== 4'h7) begin tests_failed++; $display("FAIL latency_edge7 cur got %h want 7", dut.cur_q); end
        wait_digit(0, ok, s);
        tests_run++;
        if (!ok || s !== 7'h70) begin tests_failed++; $display("FAIL d0_after7 got %h ok=%0d want 70", s, ok); end
        wait_digit(1, ok, s);
        tests_run++;
        if (!ok || s !== 7'h7E) begin tests_failed++; $display("FAIL d1_after7 got %h ok=%0d want 7E", s, ok); end
        wait_digit(2, ok, s);
        tests_run++;
        if (!ok || s !== 7'h00) begin tests_failed++; $display("FAIL d2_blank got %h ok=%0d want 00", s, ok); end
        tests_run++;
        if (led !== 4'hF) begin tests_failed++; $display("FAIL led_after7 got %h want F", led); end
        switch = 4'h9;
        repeat (10) @(negedge clk);
        wait_digit(0, ok, s);
        tests_run++;
        if (!ok || s !== 7'h5F) begin tests_failed++; $display("FAIL d0_after6 got %h ok=%0d want 5F", s, ok); end
        wait_digit(1, ok, s);
        tests_run++;
        if (!ok || s !== 7'h70) begin tests_failed++; $display("FAIL d1_after6 got %h ok=%0d want 70", s, ok); end
        wait_digit(2, ok, s);
        tests_run++;
        if (!ok || s !== 7'h7E) begin tests_failed++; $display("FAIL d2_after6 got %h ok=%0d want 7E", s, ok); end
        tests_run++;
        if (led !== 4'h8) begin tests_failed++; $display("FAIL led_after6 got %h want 8", led); end
    endtask

    task automatic test_glitch();
        switch = 4'hE;
        repeat (3) @(negedge clk);
        switch = 4'h9;
        repeat (20) @(negedge clk);
        tests_run++;
        if (dut.cur_q !== 4'h6) begin tests_failed++; $display("FAIL glitch_cur got %h want 6", dut.cur_q); end
        tests_run++;
        if (dut.hist_cnt_q !== 3'd2) begin tests_failed++; $display("FAIL glitch_hist_cnt got %0d want 2", dut.hist_cnt_q); end
        tests_run++;
        if (led !== 4'h8) begin tests_failed++; $display("FAIL glitch_led got %h want 8", led); end
    endtask

    task automatic test_overflow();
        logic [3:0] vals [5] = '{4'h1, 4'hD, 4'hF, 4'h3, 4'h5};
        logic [6:0] exp_seg [8];
        bit ok;
        logic [6:0] s;
        exp_seg = '{7'h5B, 7'h79, 7'h47, 7'h3D, 7'h30, 7'h00, 7'h00, 7'h00};
`ifdef SHOW_SW_CHG_CNT_EN
        exp_seg[7] = 7'h70;
`endif
        for (int i = 0; i < 5; i++) begin
            switch = ~vals[i];
            repeat (20) @(negedge clk);
        end
        tests_run++;
        if (dut.hist_cnt_q !== 3'd4) begin tests_failed++; $display("FAIL ovf_hist_cnt got %0d want 4", dut.hist_cnt_q); end
        tests_run++;
        if (led !== 4'hC) begin tests_failed++; $display("FAIL ovf_led got %h want C", led); end
        for (int d = 0; d < 8; d++) begin
            wait_digit(d, ok, s);
            tests_run++;
            if (!ok || s !== exp_seg[d]) begin
                tests_failed++;
                $display("FAIL ovf_digit%0d got %h ok=%0d want %h", d, s, ok, exp_seg[d]);
            end
        end
    endtask

    task automatic test_scan();
        logic [6:0] exp_seg [8];
        logic [7:0] prev, sel;
        bit found;
        int d;
        exp_seg = '{7'h5B, 7'h79, 7'h47, 7'h3D, 7'h30, 7'h00, 7'h00, 7'h00};
`ifdef SHOW_SW_CHG_CNT_EN
        exp_seg[7] = 7'h70;
`endif
        found = 1'b0;
        prev = num_csn;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (num_csn == 8'hFE && prev != 8'hFE) begin found = 1'b1; break; end
            prev = num_csn;
        end
        tests_run++;
        if (!found) begin tests_failed++; $display("FAIL scan_sync got %h want FE entry", num_csn); end
        for (int i = 0; i < 32; i++) begin
            d = (i / 2) % 8;
            sel = 8'b1 << d;
            tests_run++;
            if (num_csn !== ~sel) begin tests_failed++; $display("FAIL scan_csn cyc%0d got %h want %h", i, num_csn, ~sel); end
            tests_run++;
            if (num_a_g !== exp_seg[d]) begin tests_failed++; $display("FAIL scan_seg cyc%0d got %h want %h", i, num_a_g, exp_seg[d]); end
            @(negedge clk);
        end
        tests_run++;
        if (num_csn !== 8'hFE) begin tests_failed++; $display("FAIL scan_wrap got %h want FE", num_csn); end
    endtask

    task automatic test_reset_midrun();
        bit ok;
        logic [6:0] s;
        resetn = 1'b0;
        switch = 4'hF;
        @(negedge clk);
        tests_run++;
        if (num_csn !== 8'hFF || num_a_g !== 7'h00) begin
            tests_failed++; $display("FAIL mid_reset_disp got %h/%h want FF/00", num_csn, num_a_g);
        end
        tests_run++;
        if (led !== 4'hF) begin tests_failed++; $display("FAIL mid_reset_led got %h want F", led); end
        tests_run++;
        if (dut.hist_cnt_q !== 3'd0 || dut.cur_q !== 4'h0) begin
            tests_failed++; $display("FAIL mid_reset_state got cnt=%0d cur=%h want 0/0", dut.hist_cnt_q, dut.cur_q);
        end
        resetn = 1'b1;
        repeat (20) @(negedge clk);
        wait_digit(0, ok, s);
        tests_run++;
        if (!ok || s !== 7'h7E) begin tests_failed++; $display("FAIL post_reset_d0 got %h ok=%0d want 7E", s, ok); end
        wait_digit(1, ok, s);
        tests_run++;
        if (!ok || s !== 7'h00) begin tests_failed++; $display("FAIL post_reset_d1 got %h ok=%0d want 00", s, ok); end
        tests_run++;
        if (led !== 4'hF) begin tests_failed++; $display("FAIL post_reset_led got %h want F", led); end
        wait_digit(7, ok, s);
        tests_run++;
`ifdef SHOW_SW_CHG_CNT_EN
        if (!ok || s !== 7'h7E) begin tests_failed++; $display("FAIL post_reset_d7 got %h ok=%0d want 7E", s, ok); end
`else
        if (!ok || s !== 7'h00) begin tests_failed++; $display("FAIL post_reset_d7 got %h ok=%0d want 00", s, ok); end
`endif
        for (int v = 1; v <= 8; v++) begin
            switch = ~4'(v);
            repeat (10) @(negedge clk);
        end
        wait_digit(7, ok, s);
        tests_run++;
`ifdef SHOW_SW_CHG_CNT_EN
        if (!ok || s !== 7'h7F) begin tests_failed++; $display("FAIL chg8_d7 got %h ok=%0d want 7F", s, ok); end
`else
        if (!ok || s !== 7'h00) begin tests_failed++; $display("FAIL chg8_d7 got %h ok=%0d want 00", s, ok); end
`endif
        tests_run++;
        if (led !== 4'h8) begin tests_failed++; $display("FAIL chg8_led got %h want 8", led); end
    endtask

    initial begin
        resetn = 1'b0;
        switch = 4'hF;
        test_reset();
        test_debounce();
        test_glitch();
        test_overflow();
        test_scan();
        test_reset_midrun();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
